// File: rtl/axis_burst_player.sv
// Burst player between a 256-bit AXI-Stream FIFO and a DAC stream: emits burst_len beats per
// trigger and fills with zeros on FIFO underflow. Optional tlast output: AXIS_BURST_PLAYER_TLAST_EN.
module axis_burst_player #(
  parameter int DATA_WIDTH = 256,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  axis_clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
`ifdef AXIS_BURST_PLAYER_TLAST_EN
  output logic                  m_axis_tlast,
`endif
  input  logic                  arm,
  input  logic                  trigger,
  input  logic                  abort,
  input  logic [CNT_WIDTH-1:0]  burst_len,
  output logic                  busy,
  output logic                  done,
  output logic                  underflow,
  output logic [CNT_WIDTH-1:0]  beats_sent
);

  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  len_q, len_d;
  logic [CNT_WIDTH-1:0]  load_cnt_q, load_cnt_d;
  logic [CNT_WIDTH-1:0]  beats_q, beats_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  uflow_q, uflow_d;
  logic                  accept_s, arm_ok_s, load_en_s, last_load_s, abort_s;

  assign accept_s    = tvalid_q && m_axis_tready;
  assign arm_ok_s    = arm && (burst_len != CNT_ZERO);
  assign abort_s     = abort && (state_q != S_IDLE);
  assign last_load_s = (load_cnt_q == (len_q - CNT_ONE));
  // A load may overwrite the output register only when it is empty or being drained this cycle.
  assign load_en_s   = (state_q == S_RUN) && !abort && (!tvalid_q || m_axis_tready) &&
                       (load_cnt_q < len_q);

  // State register.
  always_ff @(posedge axis_clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides every other event.
  always_comb begin
    state_d = state_q;
    if (abort_s) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (arm_ok_s) state_d = S_ARMED; else state_d = S_IDLE;
        S_ARMED: if (trigger) state_d = S_RUN; else state_d = S_ARMED;
        S_RUN:   if (load_en_s && last_load_s) state_d = S_FLUSH; else state_d = S_RUN;
        S_FLUSH: if (accept_s) state_d = S_IDLE; else state_d = S_FLUSH;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State-decoded outputs.
  always_comb begin
    s_axis_tready = load_en_s;
    busy          = (state_q != S_IDLE);
    done          = (state_q == S_FLUSH) && accept_s && !abort;
  end

  // Datapath next-state: output stage, counters and sticky underflow.
  always_comb begin
    len_d      = len_q;
    load_cnt_d = load_cnt_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    uflow_d    = uflow_q;
    if (accept_s && (beats_q != CNT_MAX)) begin
      beats_d = beats_q + CNT_ONE;
    end else begin
      beats_d = beats_q;
    end
    if (abort_s) begin
      tvalid_d = 1'b0;
    end else begin
      if (load_en_s) begin
        tvalid_d   = 1'b1;
        load_cnt_d = load_cnt_q + CNT_ONE;
        if (s_axis_tvalid) begin
          tdata_d = s_axis_tdata;
        end else begin
          tdata_d = DATA_ZERO;
          uflow_d = 1'b1;
        end
      end else if (accept_s) begin
        tvalid_d = 1'b0;
      end else begin
        tvalid_d = tvalid_q;
      end
      if (arm_ok_s && ((state_q == S_IDLE) || (state_q == S_ARMED))) begin
        len_d   = burst_len;
        uflow_d = 1'b0;
        beats_d = CNT_ZERO;
      end else begin
        len_d = len_q;
      end
      if ((state_q == S_ARMED) && trigger) begin
        load_cnt_d = CNT_ZERO;
      end else begin
        load_cnt_d = load_cnt_d;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge axis_clk) begin
    if (!rst) begin
      len_q      <= CNT_ZERO;
      load_cnt_q <= CNT_ZERO;
      beats_q    <= CNT_ZERO;
      tdata_q    <= DATA_ZERO;
      tvalid_q   <= 1'b0;
      uflow_q    <= 1'b0;
    end else begin
      len_q      <= len_d;
      load_cnt_q <= load_cnt_d;
      beats_q    <= beats_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      uflow_q    <= uflow_d;
    end
  end

`ifdef AXIS_BURST_PLAYER_TLAST_EN
  logic tlast_q, tlast_d;

  // tlast travels with the data of the final load.
  always_comb begin
    if (abort_s) begin
      tlast_d = 1'b0;
    end else if (load_en_s) begin
      tlast_d = last_load_s;
    end else begin
      tlast_d = tlast_q;
    end
  end

  // tlast register.
  always_ff @(posedge axis_clk) begin
    if (!rst) begin
      tlast_q <= 1'b0;
    end else begin
      tlast_q <= tlast_d;
    end
  end

  assign m_axis_tlast = tlast_q;
`endif

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign underflow     = uflow_q;
  assign beats_sent    = beats_q;

endmodule
